// File: rtl/bridge_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : bridge_arbiter
// Description : Two-port round-robin arbiter for the external bridge, with
//               port-0 line lock and an acknowledge watchdog.
// Revision    : 1.0
// =============================================================================
module bridge_arbiter #(
    parameter int ADDR_BITS      = 26,
    parameter int DATA_BITS      = 128,
    parameter int MAX_LOCK       = 80,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_BITS-1:0]   m0_address,
    input  logic [DATA_BITS/8-1:0] m0_byte_enable,
    input  logic                   m0_read,
    input  logic                   m0_write,
    input  logic [DATA_BITS-1:0]   m0_write_data,
    input  logic                   m0_lock,
    output logic                   m0_acknowledge,
    output logic [DATA_BITS-1:0]   m0_read_data,
    input  logic [ADDR_BITS-1:0]   m1_address,
    input  logic [DATA_BITS/8-1:0] m1_byte_enable,
    input  logic                   m1_read,
    input  logic                   m1_write,
    input  logic [DATA_BITS-1:0]   m1_write_data,
    output logic                   m1_acknowledge,
    output logic [DATA_BITS-1:0]   m1_read_data,
    output logic [ADDR_BITS-1:0]   interface_address,
    output logic [DATA_BITS/8-1:0] interface_byte_enable,
    output logic                   interface_read,
    output logic                   interface_write,
    output logic [DATA_BITS-1:0]   interface_write_data,
    input  logic                   interface_acknowledge,
    input  logic [DATA_BITS-1:0]   interface_read_data,
    output logic [1:0]             grant,
    output logic                   timeout_error,
    input  logic                   timeout_clear
);

    localparam int LC_W = $clog2(MAX_LOCK + 1);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LC_W-1:0] c_MAX_LOCK = LC_W'(MAX_LOCK);
    localparam logic [WD_W-1:0] c_WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0]      r_state;
    logic            r_rr_ptr;
    logic [LC_W-1:0] r_lock_count;
    logic [WD_W-1:0] r_wd_count;
    logic            r_force_ack;
    logic            r_force_port;

    logic w_req0, w_req1, w_lock_ok, w_pick1, w_start, w_grant1;
    logic w_owning, w_timeout, w_done;

    assign w_req0    = m0_read || m0_write;
    assign w_req1    = m1_read || m1_write;
    assign w_lock_ok = m0_lock && (r_lock_count < c_MAX_LOCK);
    assign w_pick1   = w_req1 && (!w_req0 || (!w_lock_ok && r_rr_ptr));
    // The requester still holds its request during a forced-ack cycle; do not re-grant it.
    assign w_start   = (r_state == c_IDLE) && (w_req0 || w_req1) && !r_force_ack;
    assign w_grant1  = w_start && w_pick1;

    assign w_owning  = (r_state == c_OWN0) || (r_state == c_OWN1);
    assign w_timeout = w_owning && !interface_acknowledge && (r_wd_count == c_WD_LAST);
    assign w_done    = (w_owning && interface_acknowledge) || w_timeout;

    assign m0_acknowledge = ((r_state == c_OWN0) && interface_acknowledge) || (r_force_ack && !r_force_port);
    assign m1_acknowledge = ((r_state == c_OWN1) && interface_acknowledge) || (r_force_ack && r_force_port);
    assign m0_read_data   = (r_state == c_OWN0) ? interface_read_data : '0;
    assign m1_read_data   = (r_state == c_OWN1) ? interface_read_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state               <= c_IDLE;
            r_rr_ptr              <= 1'b0;
            r_lock_count          <= '0;
            r_wd_count            <= '0;
            r_force_ack           <= 1'b0;
            r_force_port          <= 1'b0;
            interface_address     <= '0;
            interface_byte_enable <= '0;
            interface_read        <= 1'b0;
            interface_write       <= 1'b0;
            interface_write_data  <= '0;
            grant                 <= 2'b00;
            timeout_error         <= 1'b0;
        end else begin
            r_force_ack <= 1'b0;
            if (timeout_clear) begin
                timeout_error <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_wd_count <= '0;
                        if (w_pick1) begin
                            interface_address     <= m1_address;
                            interface_byte_enable <= m1_byte_enable;
                            interface_write_data  <= m1_write_data;
                            interface_read        <= m1_read;
                            interface_write       <= m1_write && !m1_read;
                            grant                 <= 2'b10;
                            r_state               <= c_OWN1;
                        end else begin
                            interface_address     <= m0_address;
                            interface_byte_enable <= m0_byte_enable;
                            interface_write_data  <= m0_write_data;
                            interface_read        <= m0_read;
                            interface_write       <= m0_write && !m0_read;
                            grant                 <= 2'b01;
                            r_state               <= c_OWN0;
                        end
                    end
                end
                c_OWN0, c_OWN1: begin
                    if (w_done) begin
                        interface_read  <= 1'b0;
                        interface_write <= 1'b0;
                        grant           <= 2'b00;
                        r_state         <= c_IDLE;
                        r_rr_ptr        <= (r_state == c_OWN0);
                        if (w_timeout) begin
                            r_force_ack   <= 1'b1;
                            r_force_port  <= (r_state == c_OWN1);
                            timeout_error <= 1'b1;
                        end
                    end else begin
                        r_wd_count <= r_wd_count + WD_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (!m0_lock || w_grant1) begin
                r_lock_count <= '0;
            end else if (w_done && (r_state == c_OWN0) && (r_lock_count < c_MAX_LOCK)) begin
                r_lock_count <= r_lock_count + LC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bridge_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_bridge_arbiter
// Description : Directed self-checking bench for bridge_arbiter.
// Revision    : 1.0
// =============================================================================
module tb_bridge_arbiter;

    localparam int ADDR_BITS      = 26;
    localparam int DATA_BITS      = 128;
    localparam int BE_BITS        = DATA_BITS / 8;
    localparam int MAX_LOCK       = 4;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [1:0] c_EXP_RR   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    localparam logic [1:0] c_EXP_LOCK [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ADDR_BITS-1:0] m0_address, m1_address, interface_address;
    logic [BE_BITS-1:0]   m0_byte_enable, m1_byte_enable, interface_byte_enable;
    logic                 m0_read, m0_write, m0_lock, m0_acknowledge;
    logic                 m1_read, m1_write, m1_acknowledge;
    logic [DATA_BITS-1:0] m0_write_data, m1_write_data, m0_read_data, m1_read_data;
    logic                 interface_read, interface_write, interface_acknowledge;
    logic [DATA_BITS-1:0] interface_write_data, interface_read_data;
    logic [1:0]           grant;
    logic                 timeout_error, timeout_clear;

    always #5 clk = ~clk;

    bridge_arbiter #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .MAX_LOCK(MAX_LOCK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byte_enable(m0_byte_enable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_write_data(m0_write_data), .m0_lock(m0_lock),
        .m0_acknowledge(m0_acknowledge), .m0_read_data(m0_read_data),
        .m1_address(m1_address), .m1_byte_enable(m1_byte_enable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_write_data(m1_write_data),
        .m1_acknowledge(m1_acknowledge), .m1_read_data(m1_read_data),
        .interface_address(interface_address), .interface_byte_enable(interface_byte_enable),
        .interface_read(interface_read), .interface_write(interface_write),
        .interface_write_data(interface_write_data),
        .interface_acknowledge(interface_acknowledge), .interface_read_data(interface_read_data),
        .grant(grant), .timeout_error(timeout_error), .timeout_clear(timeout_clear)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bridge responder: acks bridge_lat cycles after a request becomes visible.
    logic                 bridge_en   = 1'b1;
    int                   bridge_lat  = 1;
    logic [DATA_BITS-1:0] bridge_data = '0;
    int                   bcnt;

    initial begin : bridge_model
        interface_acknowledge = 1'b0;
        interface_read_data   = '0;
        bcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (interface_acknowledge) begin
                interface_acknowledge = 1'b0;
                interface_read_data   = '0;
                bcnt = 0;
            end else if (bridge_en && !reset && (interface_read || interface_write)) begin
                if (bcnt == bridge_lat) begin
                    interface_acknowledge = 1'b1;
                    interface_read_data   = bridge_data;
                    bcnt = 0;
                end else begin
                    bcnt++;
                end
            end else begin
                bcnt = 0;
            end
        end
    end

    logic       other_ack;
    logic [1:0] got_g [8];

    task automatic wait_ack(input int port, input int budget, output int lat,
                            output logic [127:0] data, output logic seen);
        lat = 0; seen = 1'b0; data = '0; other_ack = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (((port == 0) ? m1_acknowledge : m0_acknowledge) == 1'b1) other_ack = 1'b1;
            if (((port == 0) ? m0_acknowledge : m1_acknowledge) == 1'b1) begin
                seen = 1'b1;
                data = (port == 0) ? m0_read_data : m1_read_data;
                break;
            end
        end
    endtask

    task automatic wait_grant(input logic [1:0] g, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant == g) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect_grants(input int n, input int budget, output int got_n);
        logic [1:0] prev;
        prev  = 2'b00;
        got_n = 0;
        for (int i = 0; i < budget && got_n < n; i++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev == 2'b00) begin
                got_g[got_n] = grant;
                got_n++;
            end
            prev = grant;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int             lat, n;
        logic [127:0]   data;
        logic           seen;

        reset = 1'b1; timeout_clear = 1'b0;
        m0_address = '0; m0_byte_enable = '0; m0_read = 1'b0; m0_write = 1'b0;
        m0_write_data = '0; m0_lock = 1'b0;
        m1_address = '0; m1_byte_enable = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_write_data = '0;

        // Reset state
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_if_read", interface_read, 1'b0);
        check("rst_timeout_error", timeout_error, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single read on port 0
        @(posedge clk); #1;
        m0_address = 26'h0000100; m0_byte_enable = '1; m0_read = 1'b1;
        bridge_lat = 3; bridge_data = 128'h01234567_89ABCDEF_00000000_DEADBEEF;
        @(negedge clk);
        check("rd_grant_pre", grant, 2'b00);
        @(negedge clk);
        check("rd_if_addr", interface_address, 26'h0000100);
        check("rd_if_read", interface_read, 1'b1);
        check("rd_grant", grant, 2'b01);
        wait_ack(0, 20, lat, data, seen);
        check("rd_ack_seen", seen, 1'b1);
        check("rd_ack_lat", lat, 3);
        check("rd_data", data, 128'h01234567_89ABCDEF_00000000_DEADBEEF);
        @(posedge clk); #1 m0_read = 1'b0;
        @(negedge clk);
        check("rd_ack_width", m0_acknowledge, 1'b0);
        check("rd_grant_idle", grant, 2'b00);

        // Write on port 1
        @(posedge clk); #1;
        m1_address = 26'h1234567; m1_byte_enable = 16'h000F;
        m1_write_data = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C; m1_write = 1'b1;
        bridge_lat = 2;
        wait_grant(2'b10, 10, seen);
        check("wr_grant", seen, 1'b1);
        check("wr_if_write", interface_write, 1'b1);
        check("wr_if_read", interface_read, 1'b0);
        check("wr_if_be", interface_byte_enable, 16'h000F);
        check("wr_if_data", interface_write_data, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C);
        check("wr_if_addr", interface_address, 26'h1234567);
        wait_ack(1, 20, lat, data, seen);
        check("wr_ack_seen", seen, 1'b1);
        check("wr_no_m0_ack", other_ack, 1'b0);
        @(posedge clk); #1 m1_write = 1'b0;
        repeat (3) @(negedge clk);

        // Contention without lock
        @(posedge clk); #1;
        bridge_lat = 1; m0_read = 1'b1; m1_read = 1'b1;
        collect_grants(6, 200, n);
        @(posedge clk); #1 m0_read = 1'b0; m1_read = 1'b0;
        check("rr_count", n, 6);
        for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), got_g[i], c_EXP_RR[i]);
        repeat (6) @(negedge clk);
        check("rr_idle", grant, 2'b00);

        // Contention with lock
        @(posedge clk); #1;
        m0_lock = 1'b1; m0_read = 1'b1; m1_read = 1'b1;
        collect_grants(6, 200, n);
        @(posedge clk); #1 m0_read = 1'b0; m1_read = 1'b0; m0_lock = 1'b0;
        check("lock_count", n, 6);
        for (int i = 0; i < 6; i++) check($sformatf("lock_grant%0d", i), got_g[i], c_EXP_LOCK[i]);
        repeat (6) @(negedge clk);

        // Watchdog timeout on port 1
        @(posedge clk); #1;
        bridge_en = 1'b0; m1_address = 26'h0000040; m1_read = 1'b1;
        wait_grant(2'b10, 10, seen);
        check("to_grant", seen, 1'b1);
        wait_ack(1, 40, lat, data, seen);
        check("to_ack_seen", seen, 1'b1);
        check("to_ack_lat", lat, 16);
        check("to_data_zero", data, 128'h0);
        check("to_error_set", timeout_error, 1'b1);
        check("to_if_read", interface_read, 1'b0);
        @(posedge clk); #1 m1_read = 1'b0;
        @(negedge clk);
        check("to_ack_width", m1_acknowledge, 1'b0);
        repeat (3) @(negedge clk);
        check("to_error_sticky", timeout_error, 1'b1);
        @(posedge clk); #1 timeout_clear = 1'b1;
        @(posedge clk); #1 timeout_clear = 1'b0;
        @(negedge clk);
        check("to_error_clear", timeout_error, 1'b0);

        // Real acknowledge in the final watchdog cycle
        @(posedge clk); #1;
        bridge_en = 1'b1; bridge_lat = 15; bridge_data = 128'h5555_0000_0000_0000_0000_0000_0000_AAAA;
        m1_read = 1'b1;
        wait_grant(2'b10, 10, seen);
        wait_ack(1, 40, lat, data, seen);
        check("edge_ack_lat", lat, 15);
        check("edge_data", data, 128'h5555_0000_0000_0000_0000_0000_0000_AAAA);
        @(posedge clk); #1 m1_read = 1'b0;
        repeat (3) @(negedge clk);
        check("edge_no_error", timeout_error, 1'b0);

        // Reset mid-transfer
        @(posedge clk); #1;
        bridge_en = 1'b0; m1_read = 1'b1;
        wait_grant(2'b10, 10, seen);
        check("mrst_owned", interface_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mrst_if_read", interface_read, 1'b0);
        check("mrst_grant", grant, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0; bridge_en = 1'b1; bridge_lat = 1;
        @(negedge clk);
        check("mrst_idle", grant, 2'b00);
        @(negedge clk);
        check("mrst_regrant", grant, 2'b10);
        wait_ack(1, 20, lat, data, seen);
        check("mrst_ack_seen", seen, 1'b1);
        @(posedge clk); #1 m1_read = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Shares the single External Bridge to Avalon Master port (interface_* signals of the QSYS system) between two requesters.
  - Port 0: display/buffer line fetcher (reads only in practice).
  - Port 1: loader/CPU-side agent (reads and writes).
- Round-robin arbitration, with a bounded lock that lets port 0 fetch a whole line back-to-back.
- A watchdog completes a transfer that never receives an acknowledge, so the display path cannot hang.
- Sits between the requesters and the system's interface port; the arbiter drives the interface.

Parameters:
- ADDR_BITS, 26, width of the interface address.
- DATA_BITS, 128, width of the interface data; byte-enable width is DATA_BITS/8.
- MAX_LOCK, 80, maximum consecutive port-0 grants under lock (one 640-pixel line at 8 pixels per transfer).
- TIMEOUT_CYCLES, 1024, grant cycles without acknowledge before a forced completion.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_BITS  port-0 address.
- m0_byte_enable  in  DATA_BITS/8  port-0 byte enables.
- m0_read  in  1  port-0 read request.
- m0_write  in  1  port-0 write request.
- m0_write_data  in  DATA_BITS  port-0 write data.
- m0_lock  in  1  port 0 requests back-to-back grants.
- m0_acknowledge  out  1  port-0 transfer done.
- m0_read_data  out  DATA_BITS  port-0 read data.
- m1_address / m1_byte_enable / m1_read / m1_write / m1_write_data / m1_acknowledge / m1_read_data: same as port 0 (no lock input).
- interface_address  out  ADDR_BITS  to bridge.
- interface_byte_enable  out  DATA_BITS/8  to bridge.
- interface_read  out  1  to bridge.
- interface_write  out  1  to bridge.
- interface_write_data  out  DATA_BITS  to bridge.
- interface_acknowledge  in  1  from bridge, one-cycle pulse.
- interface_read_data  in  DATA_BITS  from bridge, valid with acknowledge.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_error  out  1  sticky flag: a transfer was force-completed.
- timeout_clear  in  1  synchronous clear of timeout_error.

Behaviour:
- Requester protocol
  - A port requests when read or write is high.
  - It holds address, data, byte enables and read/write stable until it sees its acknowledge.
  - It drops read/write in the cycle after acknowledge, or immediately re-requests.
  - read and write both high is a protocol violation: treated as a read, write ignored.
- Reset (asynchronous, takes effect immediately, including mid-transfer)
  - State IDLE; all interface_* outputs 0; grant=00; m*_acknowledge=0; m*_read_data=0.
  - timeout_error=0; round-robin pointer = port 0; lock and watchdog counters = 0.
- State machine: IDLE, OWN0, OWN1.
  - IDLE: on a clock edge with any request, choose a winner, register its address, byte_enable, write_data and read/write into interface_*, set grant, and go to OWNx. Bridge request appears 1 cycle after the requester asserts.
  - OWNx: interface outputs held constant.
    - m<x>_acknowledge = interface_acknowledge (combinational).
    - m<x>_read_data = interface_read_data.
    - The non-owner sees acknowledge 0 and read_data 0.
  - On acknowledge edge: interface_read/write cleared and grant=00 on the next cycle; return to IDLE. Minimum 1 idle cycle between transfers.
- Winner selection in IDLE
  - Only one port requesting: that port wins.
  - Both requesting, lock condition true: port 0 wins. Lock condition = m0_lock && lock_count < MAX_LOCK.
  - Both requesting, otherwise: the port indicated by the round-robin pointer wins.
  - After any completed transfer, the pointer moves to the other port.
- lock_count
  - Increments on each port-0 completion while m0_lock is high.
  - Saturates at MAX_LOCK.
  - Clears when m0_lock is low or on any port-1 grant.
  - At MAX_LOCK with port 1 waiting, port 1 is guaranteed the next grant.
- Watchdog
  - wd_count resets on entry to OWNx and counts each OWNx cycle without acknowledge.
  - When wd_count reaches TIMEOUT_CYCLES-1, the arbiter pulses m<x>_acknowledge for 1 cycle with m<x>_read_data=0, sets timeout_error, deasserts interface_read/write, and returns to IDLE.
  - A real acknowledge arriving in the same cycle takes priority: normal completion, no error.
- timeout_clear clears timeout_error; a simultaneous set wins.
- A late bridge acknowledge arriving in IDLE is ignored; it is not forwarded to either port.

Test Plan:
- Reset mid-transfer: assert reset while in OWN1 with interface_read=1 -> interface_read=0 and grant=00 in the same cycle, before the clock edge; after release, the first request is granted normally.
- Single read: m0_read at addr 0x0000100, bridge acks 3 cycles after interface_read rises with data 0x…DEADBEEF -> interface_address=0x0000100 one cycle after the request; m0_acknowledge is 1 cycle wide; m0_read_data=0x…DEADBEEF; grant returns to 00.
- Contention, no lock: m0 and m1 continuously requesting -> grants alternate 01,10,01,10… across 6 transfers.
- Lock: m0_lock=1, m0 and m1 both requesting, MAX_LOCK=4 -> 4 consecutive port-0 grants, then 1 port-1 grant, then port 0 again.
- Write path: m1_write with byte_enable=0x000F and data pattern -> interface_write=1 with identical byte_enable, data and address; interface_read=0; m0_acknowledge stays 0.
- Timeout: TIMEOUT_CYCLES=16, bridge never acks m1_read -> m1_acknowledge pulses exactly 16 cycles after grant with read_data=0; timeout_error=1 until timeout_clear; a same-cycle real acknowledge produces no error.
